// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers (mult/multu/div/divu, mthi/mtlo).
// Latency: MULT_CYCLES / DIV_CYCLES edges from Start to HI/LO commit; mthi/mtlo commit on the Start edge.
// Backpressure: Busy is high while an op is in flight; any Start seen while Busy (or with Flush) is dropped.
//
// Ports:
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   Start, MDOp      one-cycle request and opcode (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none)
//   In0, In1         rs / rt operands, sampled on the Start edge
//   Flush            cancels the in-flight op and any same-edge Start
//   Busy             high while an op is in flight
//   HI, LO           architectural HI/LO register values
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    op, op_nxt;
  logic [31:0]   opa, opa_nxt;
  logic [31:0]   opb, opb_nxt;
  logic [31:0]   hi, hi_nxt;
  logic [31:0]   lo, lo_nxt;

  // Shared multiplier: sign-extending to 64 bits makes the low 64 bits of the
  // product correct for both signed and unsigned forms.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;

  // Shared divider on magnitudes; signs are restored afterwards. This also
  // gives 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
  logic        div_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

  always_comb begin
    mul_signed = (op == OP_MULT);
    mul_a = {{32{mul_signed & opa[31]}}, opa};
    mul_b = {{32{mul_signed & opb[31]}}, opb};
    prod  = mul_a * mul_b;

    div_signed = (op == OP_DIV);
    neg_a = div_signed & opa[31];
    neg_b = div_signed & opb[31];
    mag_a = neg_a ? (32'd0 - opa) : opa;
    mag_b = neg_b ? (32'd0 - opb) : opb;
    uq    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
    ur    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
    quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem   = neg_a ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    opa_nxt   = opa;
    opb_nxt   = opb;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      S_IDLE: begin
        if (Start && !Flush) begin
          case (MDOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_nxt = S_RUN;
              cnt_nxt   = (MDOp == OP_MULT || MDOp == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
              op_nxt    = MDOp;
              opa_nxt   = In0;
              opb_nxt   = In1;
            end
            OP_MTHI: hi_nxt = In0;
            OP_MTLO: lo_nxt = In0;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          case (op)
            OP_MULT, OP_MULTU: begin
              hi_nxt = prod[63:32];
              lo_nxt = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero runs full latency but leaves HI/LO alone.
              if (opb != 32'd0) begin
                hi_nxt = rem;
                lo_nxt = quo;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
      opa   <= '0;
      opb   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign Busy = (state == S_RUN);
  assign HI   = hi;
  assign LO   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] In0;
  logic [31:0] In1;
  logic        Flush;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int nvec = 0;
  int nmis = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp),
    .In0(In0), .In1(In1), .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a one-cycle Start; returns #1 after the issue edge with the
  // operand inputs scrambled so latching is exercised.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MDOp = op; In0 = a; In1 = b;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0; In0 = 32'hDEAD_BEEF; In1 = 32'h0BAD_F00D;
  endtask

  // Full op: checks Busy length and final HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    issue(op, a, b);
    chk({tag, " busy_at_issue"}, 32'(Busy), 32'd1);
    cyc = 0;
    while (Busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " busy_cycles"}, 32'(cyc), 32'(cycles));
    chk({tag, " hi"}, HI, ehi);
    chk({tag, " lo"}, LO, elo);
  endtask

  initial begin
    reset_n = 1'b0; Start = 1'b0; MDOp = 3'd0; In0 = '0; In1 = '0; Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("mult -2*3",   3'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu max^2", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult 7*-5",   3'd1, 32'd7,         32'hFFFF_FFFB, 5, 32'hFFFF_FFFF, 32'hFFFF_FFDD);
    run_op("div -7/2",    3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2",    3'd4, 32'd7,         32'd2,        10, 32'd1,         32'd3);

    // mthi / mtlo on consecutive edges
    issue(3'd5, 32'h1234, 32'd0);
    chk("mthi hi", HI, 32'h1234);
    chk("mthi busy", 32'(Busy), 32'd0);
    issue(3'd6, 32'h5678, 32'd0);
    chk("mtlo lo", LO, 32'h5678);
    chk("mtlo hi kept", HI, 32'h1234);

    run_op("div by 0", 3'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

    // div, ignored mtlo at cycle 3, flush at cycle 4
    issue(3'd3, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    Start = 1'b1; MDOp = 3'd6; In0 = 32'hAAAA;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0;
    chk("mtlo while busy lo", LO, 32'h5678);
    chk("busy before flush", 32'(Busy), 32'd1);
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("flush busy", 32'(Busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("flush hi", HI, 32'h1234);
    chk("flush lo", LO, 32'h5678);

    // Flush with Start on the same idle edge drops the Start
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd5; In0 = 32'h7777; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0; Flush = 1'b0;
    chk("flush+mthi hi", HI, 32'h1234);

    // Reset mid-mult
    issue(3'd1, 32'd5, 32'd6);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset busy", 32'(Busy), 32'd0);
    chk("midreset hi", HI, 32'd0);
    chk("midreset lo", LO, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midreset no commit lo", LO, 32'd0);

    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // Start (mult) on the commit edge of divu 100/7 is ignored
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    chk("pre-commit busy", 32'(Busy), 32'd1);
    Start = 1'b1; MDOp = 3'd1; In0 = 32'd2; In1 = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0;
    chk("commit-edge busy", 32'(Busy), 32'd0);
    chk("commit-edge lo", LO, 32'd14);
    chk("commit-edge hi", HI, 32'd2);
    repeat (7) @(posedge clk);
    #1;
    chk("commit-edge later busy", 32'(Busy), 32'd0);
    chk("commit-edge later lo", LO, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with fixed latencies and performs mthi/mtlo writes.
- Raises Busy so hazard control stalls later mfhi/mflo/MD instructions; supports flush on exception.

Parameters:
MULT_CYCLES, 5, cycles from Start edge to HI/LO commit for mult/multu (>=1)
DIV_CYCLES, 10, cycles from Start edge to HI/LO commit for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle request; MDOp/In0/In1 sampled at this edge
MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
In0  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
In1  input  32  rt operand (divisor / multiplier)
Flush  input  1  exception/flush: abort in-flight op, drop same-cycle Start
Busy  output  1  high while an op is in flight
HI  output  32  HI register (read by mfhi)
LO  output  32  LO register (read by mflo)

Behaviour:
- Reset (async, reset_n=0): HI=0, LO=0, Busy=0, counter=0, latched operands/op cleared. Reset mid-operation aborts; no commit afterwards.
- Idle, Start=1, Flush=0 at edge t0:
  - MDOp 1-4: latch op, In0, In1; load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from t0.
  - MDOp 5: HI<=In0 at t0, Busy stays 0, zero latency. MDOp 6: LO<=In0 likewise.
  - MDOp 0/7: no effect.
- Running: counter decrements each edge. At edge t0+N (N = latency): HI/LO written and Busy falls at that same edge. Busy is high for exactly N cycles.
- Start while Busy=1: ignored, including mthi/mtlo (hazard unit must stall). Running op unaffected.
- Start on the commit edge (Busy=1 before edge): ignored.
- Flush=1 at any edge: in-flight op cancelled, Busy<=0, HI/LO unchanged; a Start at that same edge is also ignored.
- State machine: IDLE --Start & MDOp in 1..4 & !Flush--> RUN; RUN --counter==1 edge--> IDLE (commit); RUN --Flush--> IDLE (no commit).
- Arithmetic is performed on latched operands, so later changes to In0/In1 have no effect. Implementation may compute at latch or at commit; the result is identical.
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
- Divisor 0 (div/divu): full latency and Busy behaviour, HI/LO left unchanged.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO outputs are direct register values; no forwarding of pending results.

Test Plan:
- Reset, then mult In0=0xFFFFFFFE(-2), In1=3 -> Busy high 5 cycles; at commit HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu In0=0xFFFFFFFF, In1=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div In0=0xFFFFFFF9(-7), In1=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- mthi 0x1234 then mtlo 0x5678 on consecutive cycles -> HI/LO update at each edge, Busy=0. Then div by 0 -> Busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
- div started, Start mtlo 0xAAAA at cycle 3 ignored, Flush at cycle 4 -> Busy drops next edge, HI/LO keep prior values. Assert reset_n low mid-mult -> HI=LO=0, Busy=0 immediately, no later commit.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Start held with a new mult on the commit edge -> ignored, Busy stays 0 afterwards.
